nn_driver: RTL
==============

NN_DRIVER -- requirements
Module: nn_driver

Interface
REQ-001 Parameter FIRST_LATENCY, default 16: cycles from the first nn_enable pulse after reset to a valid nn result, including weight load.
REQ-002 Parameter RUN_LATENCY, default 5: cycles from a later nn_enable pulse to a valid nn result.
REQ-003 Parameter FIFO_DEPTH, default 4: number of input-pair queue entries, a power of 2.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-low; the ports are clk and resetn.
REQ-005 Ports (name  direction  width  meaning):
  clk  in  1  clock
  resetn  in  1  sync active-low reset
  in_valid  in  1  host offers an input pair
  in_ready  out  1  queue can accept
  in_a  in  32  input_1 value
  in_b  in  32  input_2 value
  nn_input_1  out  32  drives nn input_1
  nn_input_2  out  32  drives nn input_2
  nn_enable  out  1  one-cycle start pulse to nn
  nn_final_output  in  32  nn result
  nn_total_ovf  in  1  nn overflow flag
  nn_total_zero  in  1  nn zero flag
  nn_ovf_stage  in  3  nn overflow stage
  nn_zero_stage  in  3  nn zero stage
  out_valid  out  1  result available
  out_ready  in  1  consumer accepts the result
  out_data  out  32  captured result
  out_ovf  out  1  captured overflow flag
  out_zero  out  1  captured zero flag
  out_ovf_stage  out  3  captured overflow stage
  out_zero_stage  out  3  captured zero stage
  run_count  out  16  completed runs, wraps 0xFFFF->0
  busy  out  1  high in any state other than D_IDLE

Function
REQ-006 Input queue: a push occurs on in_valid&&in_ready; in_ready=0 when the queue is full, even if a pop happens in the same cycle; a simultaneous push and pop while not full and not empty SHALL both take effect.
REQ-007 The FSM SHALL have the states D_IDLE, D_ISSUE, D_WAIT and D_HOLD.
REQ-008 D_IDLE: if the queue is not empty, pop its head into the nn_input_1/2 registers and go to D_ISSUE; otherwise stay in D_IDLE.
REQ-009 D_ISSUE: assert nn_enable=1 for exactly this cycle, load the wait counter, and go to D_WAIT; nn_enable SHALL be 0 in every other state.
REQ-010 Latency SHALL be FIRST_LATENCY if first_done=0 and RUN_LATENCY otherwise; first_done is set at the first capture after reset.
REQ-011 If the ISSUE cycle is t and the selected latency is L, capture all nn_* result inputs into the out_* registers at the clock edge ending cycle t+L, then go to D_HOLD with out_valid=1 from cycle t+L+1.
REQ-012 nn_input_1/2 SHALL hold stable from D_ISSUE until capture.
REQ-013 D_HOLD: on out_valid&&out_ready, clear out_valid, increment run_count and go to D_IDLE; if out_ready stays low, hold the outputs and issue no new run.
REQ-014 An nn overflow-driven early finish SHALL need no special handling: the full latency is still waited, and out_data is captured as 0xFFFFFFFF.
REQ-015 out_* registers SHALL change only at capture.

Reset
REQ-016 While resetn=0 at clk: state=D_IDLE, queue empty, in_ready=1, out_valid=0, nn_enable=0, nn_input_1/2=0, out_data=0, out_ovf=0, out_zero=0, out_ovf_stage=3'b111, out_zero_stage=3'b111, run_count=0, first_done=0, busy=0.
REQ-017 A reset mid-run SHALL abort the run, discard queued pairs, and make the next run use FIRST_LATENCY.

Structure
REQ-018 The shared package SHALL hold the D_* state encoding, the FIRST_LATENCY/RUN_LATENCY defaults, OVF_VALUE=0xFFFFFFFF and the stage-reset value 3'b111.
REQ-019 The queue SHALL be one sub-module, nn_drv_fifo: a synchronous FIFO, 64-bit wide, FIFO_DEPTH deep, with full and empty outputs.

Verification (bench with driver connected to nn)
REQ-020 First pair after reset, a=40, b=20, enable asserted at cycle t: out_valid at t+17, out_data=3256, ovf=0, zero=0, run_count=1 after accept.
REQ-021 Second pair a=0, b=0: out_data=216, out_zero=1, out_zero_stage=3'b011, out_valid 6 cycles after its ISSUE.
REQ-022 Pair a=0x7FFFFFFF, b=1: out_data=0xFFFFFFFF, out_ovf=1, out_ovf_stage=3'b011; the next pair (40, 20) returns 3256 with ovf=0.
REQ-023 Push 5 pairs back-to-back with out_ready=0: in_ready drops after the queue fills, exactly one nn_enable pulse occurs, and results arrive in push order once out_ready=1.
REQ-024 resetn pulsed low during D_WAIT: all outputs return to their reset values; the next pair uses the 16-cycle latency and returns the correct result.

Source files
------------

// File: rtl/nn_driver_pkg.sv
// Shared definitions for the nn driver: FSM encoding, default latencies and
// the fixed values the driver captures or resets to.
package nn_driver_pkg;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2,
    D_HOLD  = 2'd3
  } drv_state_e;

  localparam int unsigned FIRST_LATENCY_DEF = 16;
  localparam int unsigned RUN_LATENCY_DEF   = 5;
  localparam int unsigned CNT_W             = 16;

  localparam logic [31:0] OVF_VALUE = 32'hFFFF_FFFF;
  localparam logic [2:0]  STAGE_RST = 3'b111;

endpackage

// File: rtl/nn_drv_fifo.sv
// Synchronous FIFO holding queued input pairs; pointers carry an extra wrap
// bit so full and empty are distinguishable without an occupancy counter.
module nn_drv_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nn_driver.sv
// Drives a fixed-latency nn block: queues input pairs, issues one run at a
// time, waits the known latency and holds the captured result until accepted.
module nn_driver
  import nn_driver_pkg::*;
#(
  parameter int unsigned FIRST_LATENCY = FIRST_LATENCY_DEF,
  parameter int unsigned RUN_LATENCY   = RUN_LATENCY_DEF,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] nn_input_1,
  output logic [31:0] nn_input_2,
  output logic        nn_enable,
  input  logic [31:0] nn_final_output,
  input  logic        nn_total_ovf,
  input  logic        nn_total_zero,
  input  logic [2:0]  nn_ovf_stage,
  input  logic [2:0]  nn_zero_stage,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_zero,
  output logic [2:0]  out_ovf_stage,
  output logic [2:0]  out_zero_stage,
  output logic [15:0] run_count,
  output logic        busy
);

  localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(FIRST_LATENCY - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(RUN_LATENCY - 1);

  drv_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_done_q;
  logic [31:0]      in1_q, in2_q;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic             out_ovf_q, out_zero_q;
  logic [2:0]       out_ovf_stage_q, out_zero_stage_q;
  logic [15:0]      run_count_q;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [63:0]      fifo_rdata;
  logic             capture, accept;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  nn_drv_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  ({in_a, in_b}),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      D_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = D_ISSUE;
        end
      end
      D_ISSUE: begin
        // Counter ends at zero in the last cycle of the latency window.
        cnt_d   = first_done_q ? RUN_LOAD : FIRST_LOAD;
        state_d = D_WAIT;
      end
      D_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = D_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      D_HOLD: begin
        if (out_ready) begin
          accept  = 1'b1;
          state_d = D_IDLE;
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= D_IDLE;
      cnt_q            <= '0;
      first_done_q     <= 1'b0;
      in1_q            <= '0;
      in2_q            <= '0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_ovf_q        <= 1'b0;
      out_zero_q       <= 1'b0;
      out_ovf_stage_q  <= STAGE_RST;
      out_zero_stage_q <= STAGE_RST;
      run_count_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fifo_pop) begin
        in1_q <= fifo_rdata[63:32];
        in2_q <= fifo_rdata[31:0];
      end
      if (capture) begin
        out_valid_q      <= 1'b1;
        out_data_q       <= nn_total_ovf ? OVF_VALUE : nn_final_output;
        out_ovf_q        <= nn_total_ovf;
        out_zero_q       <= nn_total_zero;
        out_ovf_stage_q  <= nn_ovf_stage;
        out_zero_stage_q <= nn_zero_stage;
        first_done_q     <= 1'b1;
      end
      if (accept) begin
        out_valid_q <= 1'b0;
        run_count_q <= run_count_q + 16'd1;
      end
    end
  end

  assign nn_enable      = (state_q == D_ISSUE);
  assign busy           = (state_q != D_IDLE);
  assign nn_input_1     = in1_q;
  assign nn_input_2     = in2_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_ovf        = out_ovf_q;
  assign out_zero       = out_zero_q;
  assign out_ovf_stage  = out_ovf_stage_q;
  assign out_zero_stage = out_zero_stage_q;
  assign run_count      = run_count_q;

endmodule
